// File: rtl/uart_rx_fifo.sv
// Receive-side frame FIFO for a UART: stores {ferror, perror, data} entries,
// serves a registered one-cycle-latency read port, and keeps overrun/error stats.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DROP_BAD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_frame,
    input  logic [7:0]        wr_data,
    input  logic              wr_perror,
    input  logic              wr_ferror,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_perror,
    output logic              rd_ferror,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_status,
    output logic [7:0]        perr_cnt,
    output logic [7:0]        ferr_cnt
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

    logic [9:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_perror_q, rd_perror_d;
    logic              rd_ferror_q, rd_ferror_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        perr_cnt_q, perr_cnt_d;
    logic [7:0]        ferr_cnt_q, ferr_cnt_d;

    logic              bad;
    logic              drop_bad;
    logic              rd_accept;
    logic              wr_accept;
    logic              overrun_event;
    logic [9:0]        rd_entry;

    // A pending event takes priority over a clear in the same cycle.
    function automatic logic [7:0] next_err_cnt(input logic [7:0] cur,
                                                input logic       hit,
                                                input logic       clr);
        logic [7:0] result;
        result = cur;
        if (hit) begin
            if (clr) begin
                result = 8'd1;
            end else if (cur != 8'hFF) begin
                result = cur + 8'd1;
            end
        end else if (clr) begin
            result = 8'd0;
        end
        return result;
    endfunction

    always_comb begin
        bad           = wr_perror | wr_ferror;
        drop_bad      = (DROP_BAD != 0) && bad;
        rd_accept     = rd_en && (count_q != '0);
        wr_accept     = wr_frame && !drop_bad && ((count_q != FULL_COUNT) || rd_accept);
        overrun_event = wr_frame && !drop_bad && (count_q == FULL_COUNT) && !rd_accept;
        rd_entry      = mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_perror_d = rd_perror_q;
        rd_ferror_d = rd_ferror_q;
        rd_valid_d  = 1'b0;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (rd_accept) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            rd_data_d   = rd_entry[7:0];
            rd_perror_d = rd_entry[8];
            rd_ferror_d = rd_entry[9];
            rd_valid_d  = 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (overrun_event) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        perr_cnt_d = next_err_cnt(perr_cnt_q, wr_frame && wr_perror, clr_status);
        ferr_cnt_d = next_err_cnt(ferr_cnt_q, wr_frame && wr_ferror, clr_status);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= 8'd0;
            rd_perror_q <= 1'b0;
            rd_ferror_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            perr_cnt_q  <= 8'd0;
            ferr_cnt_q  <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_perror_q <= rd_perror_d;
            rd_ferror_q <= rd_ferror_d;
            rd_valid_q  <= rd_valid_d;
            overrun_q   <= overrun_d;
            perr_cnt_q  <= perr_cnt_d;
            ferr_cnt_q  <= ferr_cnt_d;
        end
    end

    // Storage has no reset; when full, a simultaneous read sees the old entry.
    always_ff @(posedge clk) begin
        if (reset && wr_accept) begin
            mem_q[wr_ptr_q] <= {wr_ferror, wr_perror, wr_data};
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_perror = rd_perror_q;
    assign rd_ferror = rd_ferror_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign overrun   = overrun_q;
    assign perr_cnt  = perr_cnt_q;
    assign ferr_cnt  = ferr_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the FIFO.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b0;
    logic              wr_frame = 1'b0;
    logic [7:0]        wr_data = 8'd0;
    logic              wr_perror = 1'b0;
    logic              wr_ferror = 1'b0;
    logic              rd_en = 1'b0;
    logic              clr_status = 1'b0;
    logic [7:0]        rd_data;
    logic              rd_perror, rd_ferror, rd_valid, empty, full, overrun;
    logic [ADDR_W:0]   count;
    logic [7:0]        perr_cnt, ferr_cnt;

    logic              b_wr_frame = 1'b0;
    logic [7:0]        b_wr_data = 8'd0;
    logic              b_wr_perror = 1'b0;
    logic              b_wr_ferror = 1'b0;
    logic              b_rd_en = 1'b0;
    logic              b_clr_status = 1'b0;
    logic [7:0]        b_rd_data;
    logic              b_rd_perror, b_rd_ferror, b_rd_valid, b_empty, b_full, b_overrun;
    logic [ADDR_W:0]   b_count;
    logic [7:0]        b_perr_cnt, b_ferr_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_BAD(0)) dut_keep (
        .clk(clk), .reset(reset),
        .wr_frame(wr_frame), .wr_data(wr_data), .wr_perror(wr_perror), .wr_ferror(wr_ferror),
        .rd_en(rd_en), .rd_data(rd_data), .rd_perror(rd_perror), .rd_ferror(rd_ferror),
        .rd_valid(rd_valid), .empty(empty), .full(full), .count(count), .overrun(overrun),
        .clr_status(clr_status), .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt)
    );

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_BAD(1)) dut_drop (
        .clk(clk), .reset(reset),
        .wr_frame(b_wr_frame), .wr_data(b_wr_data), .wr_perror(b_wr_perror), .wr_ferror(b_wr_ferror),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_perror(b_rd_perror), .rd_ferror(b_rd_ferror),
        .rd_valid(b_rd_valid), .empty(b_empty), .full(b_full), .count(b_count), .overrun(b_overrun),
        .clr_status(b_clr_status), .perr_cnt(b_perr_cnt), .ferr_cnt(b_ferr_cnt)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    logic [9:0] mq[$];
    int         m_perr = 0;
    int         m_ferr = 0;
    bit         m_over = 0;
    int         m_rd_data = 0;
    bit         m_rd_pe = 0;
    bit         m_rd_fe = 0;
    bit         m_rd_valid = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic counterUpdate(inout int cnt, input bit hit, input bit clr);
        if (hit) cnt = clr ? 1 : ((cnt >= 255) ? 255 : cnt + 1);
        else if (clr) cnt = 0;
    endtask

    // Reference behaviour for the DROP_BAD=0 instance: a plain bounded queue.
    task automatic modelStep(input bit rst_n, input bit wf, input logic [7:0] d,
                             input bit pe, input bit fe, input bit rd, input bit clr);
        logic [9:0] e;
        bit rd_acc;
        bit over_evt;
        if (!rst_n) begin
            mq.delete();
            m_perr = 0; m_ferr = 0; m_over = 0;
            m_rd_data = 0; m_rd_pe = 0; m_rd_fe = 0; m_rd_valid = 0;
            return;
        end
        rd_acc = rd && (mq.size() > 0);
        m_rd_valid = rd_acc;
        if (rd_acc) begin
            e = mq.pop_front();
            m_rd_data = int'(e[7:0]);
            m_rd_pe = e[8];
            m_rd_fe = e[9];
        end
        over_evt = 0;
        if (wf) begin
            if (mq.size() < DEPTH) mq.push_back({fe, pe, d});
            else over_evt = 1;
        end
        if (over_evt) m_over = 1;
        else if (clr) m_over = 0;
        counterUpdate(m_perr, wf && pe, clr);
        counterUpdate(m_ferr, wf && fe, clr);
    endtask

    task automatic checkAll();
        checkOutput("count",     int'(count),     mq.size());
        checkOutput("empty",     int'(empty),     (mq.size() == 0) ? 1 : 0);
        checkOutput("full",      int'(full),      (mq.size() == DEPTH) ? 1 : 0);
        checkOutput("overrun",   int'(overrun),   int'(m_over));
        checkOutput("perr_cnt",  int'(perr_cnt),  m_perr);
        checkOutput("ferr_cnt",  int'(ferr_cnt),  m_ferr);
        checkOutput("rd_valid",  int'(rd_valid),  int'(m_rd_valid));
        checkOutput("rd_data",   int'(rd_data),   m_rd_data);
        checkOutput("rd_perror", int'(rd_perror), int'(m_rd_pe));
        checkOutput("rd_ferror", int'(rd_ferror), int'(m_rd_fe));
    endtask

    task automatic applyStimulus(input bit rst_n, input bit wf, input logic [7:0] d,
                                 input bit pe, input bit fe, input bit rd, input bit clr);
        reset = rst_n; wr_frame = wf; wr_data = d; wr_perror = pe; wr_ferror = fe;
        rd_en = rd; clr_status = clr;
        @(posedge clk);
        #1;
        modelStep(rst_n, wf, d, pe, fe, rd, clr);
        checkAll();
        wr_frame = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
    endtask

    task automatic writeFrame(input logic [7:0] d, input bit pe, input bit fe);
        applyStimulus(1, 1, d, pe, fe, 0, 0);
    endtask

    task automatic readOne();
        applyStimulus(1, 0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
    endtask

    logic [7:0] t1_vals [3];

    initial begin
        t1_vals[0] = 8'h55; t1_vals[1] = 8'hA3; t1_vals[2] = 8'h0F;

        doReset();
        checkOutput("reset_empty", int'(empty), 1);
        checkOutput("reset_count", int'(count), 0);

        $display("[TB] basic write/read order");
        for (int i = 0; i < 3; i++) begin
            writeFrame(t1_vals[i], 0, 0);
            checkOutput("t1_count_up", int'(count), i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            readOne();
            checkOutput("t1_rd_valid", int'(rd_valid), 1);
            checkOutput("t1_rd_data", int'(rd_data), int'(t1_vals[i]));
            checkOutput("t1_count_dn", int'(count), 2 - i);
        end
        checkOutput("t1_empty", int'(empty), 1);

        $display("[TB] fill, overrun, drain, clear");
        for (int i = 0; i < DEPTH; i++) writeFrame(8'(i), 0, 0);
        writeFrame(8'hEE, 0, 0);
        checkOutput("t2_full", int'(full), 1);
        checkOutput("t2_overrun", int'(overrun), 1);
        checkOutput("t2_count", int'(count), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            readOne();
            checkOutput("t2_drain", int'(rd_data), i);
        end
        applyStimulus(1, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("t2_clr", int'(overrun), 0);

        $display("[TB] simultaneous read/write while full");
        for (int i = 0; i < DEPTH; i++) writeFrame(8'(8'h80 + i), 0, 0);
        applyStimulus(1, 1, 8'h77, 0, 0, 1, 0);
        checkOutput("t3_overrun", int'(overrun), 0);
        checkOutput("t3_count", int'(count), DEPTH);
        checkOutput("t3_full", int'(full), 1);
        checkOutput("t3_first", int'(rd_data), 8'h80);
        for (int i = 0; i < DEPTH; i++) readOne();
        checkOutput("t3_last", int'(rd_data), 8'h77);

        $display("[TB] error frames, keep vs drop");
        doReset();
        b_wr_frame = 1'b1; b_wr_data = 8'h12; b_wr_perror = 1'b1; b_wr_ferror = 1'b0;
        writeFrame(8'h12, 1, 0);
        b_wr_data = 8'h34; b_wr_perror = 1'b0; b_wr_ferror = 1'b1;
        writeFrame(8'h34, 0, 1);
        b_wr_frame = 1'b0; b_wr_perror = 1'b0; b_wr_ferror = 1'b0;
        checkOutput("t4_keep_count", int'(count), 2);
        checkOutput("t4_keep_perr", int'(perr_cnt), 1);
        checkOutput("t4_keep_ferr", int'(ferr_cnt), 1);
        checkOutput("t4_drop_count", int'(b_count), 0);
        checkOutput("t4_drop_empty", int'(b_empty), 1);
        checkOutput("t4_drop_perr", int'(b_perr_cnt), 1);
        checkOutput("t4_drop_ferr", int'(b_ferr_cnt), 1);
        readOne();
        checkOutput("t4_rd0_data", int'(rd_data), 8'h12);
        checkOutput("t4_rd0_pe", int'(rd_perror), 1);
        checkOutput("t4_rd0_fe", int'(rd_ferror), 0);
        readOne();
        checkOutput("t4_rd1_data", int'(rd_data), 8'h34);
        checkOutput("t4_rd1_pe", int'(rd_perror), 0);
        checkOutput("t4_rd1_fe", int'(rd_ferror), 1);

        $display("[TB] parity counter saturation");
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus(1, 1, 8'(i), 1, 0, 1, 0);
        checkOutput("t5_perr_sat", int'(perr_cnt), 255);
        checkOutput("t5_ferr", int'(ferr_cnt), 0);

        $display("[TB] reset mid-operation");
        doReset();
        for (int i = 0; i < 5; i++) writeFrame(8'(8'hC0 + i), 0, 0);
        applyStimulus(0, 1, 8'hAB, 0, 0, 0, 0);
        checkOutput("t6_count", int'(count), 0);
        checkOutput("t6_empty", int'(empty), 1);
        readOne();
        checkOutput("t6_no_valid", int'(rd_valid), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 99) < 60,
                          8'($urandom),
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 4);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
